// File: rtl/bc_fir_seq_if.sv
// Sample-in / result-out valid-ready bus for the sequential 19-tap FIR.
interface bc_fir_seq_if #(
   parameter int unsigned N = 12
) ();
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   // Source side of the sample stream and sink side of the result stream
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Filter side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/bc_fir_seq.sv
// Time-multiplexed 19-tap symmetric FIR: one pre-adder, multiplier and
// accumulator shared across the 6 nonzero coefficient groups.
// Optional: define BC_FIR_SEQ_SAT_EN for a saturating output instead of
// modulo-2^N truncation.
module bc_fir_seq #(
   parameter int unsigned N     = 12,
   parameter int unsigned ACC_W = N + 14
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   bc_fir_seq_if.slave  bus,
   output logic         busy
);
   localparam int unsigned TAPS   = 19;
   localparam int unsigned PAIR_W = N + 1;
   localparam int unsigned COEF_W = 10;
   localparam int unsigned PROD_W = N + 11;
   localparam int unsigned IDX_W  = 3;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(5);

   typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

   state_t             state, state_nx;
   logic [N-1:0]       dline [TAPS];
   logic [IDX_W-1:0]   idx;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_nx_c;
   logic [N-1:0]       tap_a_c, tap_b_c;
   logic [COEF_W-1:0]  coef_c;
   logic [PAIR_W-1:0]  pair_c;
   logic [PROD_W-1:0]  prod_c;
   logic [N-1:0]       res_c;
   logic               in_hs_c, out_hs_c;

   // Tap pair and coefficient for the current schedule slot
   always_comb begin
      tap_a_c = '0;
      tap_b_c = '0;
      coef_c  = '0;
      case (idx)
         3'd0: begin tap_a_c = dline[0]; tap_b_c = dline[18]; coef_c = COEF_W'(999); end
         3'd1: begin tap_a_c = dline[2]; tap_b_c = dline[16]; coef_c = COEF_W'(888); end
         3'd2: begin tap_a_c = dline[4]; tap_b_c = dline[14]; coef_c = COEF_W'(777); end
         3'd3: begin tap_a_c = dline[6]; tap_b_c = dline[12]; coef_c = COEF_W'(666); end
         3'd4: begin tap_a_c = dline[8]; tap_b_c = dline[10]; coef_c = COEF_W'(555); end
         3'd5: begin tap_a_c = dline[9]; tap_b_c = '0;        coef_c = COEF_W'(444); end
         default: ;
      endcase
   end

   // Shared pre-adder, multiplier, accumulator and output formatting
   always_comb begin
      pair_c   = PAIR_W'(tap_a_c) + PAIR_W'(tap_b_c);
      prod_c   = PROD_W'(pair_c) * PROD_W'(coef_c);
      acc_nx_c = acc + ACC_W'(prod_c);
`ifdef BC_FIR_SEQ_SAT_EN
      res_c    = (acc_nx_c > ACC_W'({N{1'b1}})) ? {N{1'b1}} : acc_nx_c[N-1:0];
`else
      res_c    = acc_nx_c[N-1:0];
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; in_ready is high only in IDLE, so the handshake implies IDLE
   always_comb begin
      state_nx = state;
      in_hs_c  = bus.in_valid & bus.in_ready;
      out_hs_c = bus.out_valid & bus.out_ready;
      case (state)
         IDLE:    if (in_hs_c) state_nx = MAC;
         MAC:     if (idx == IDX_LAST) state_nx = DONE;
         DONE:    if (out_hs_c) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Handshake and status outputs, registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         busy          <= 1'b0;
      end else begin
         bus.in_ready  <= (state_nx == IDLE);
         bus.out_valid <= (state_nx == DONE);
         busy          <= (state_nx != IDLE);
      end
   end

   // Delay line, schedule index, accumulator and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) dline[k] <= '0;
         idx          <= '0;
         acc          <= '0;
         bus.out_data <= '0;
      end else begin
         if (in_hs_c) begin
            for (int k = TAPS - 1; k > 0; k--) dline[k] <= dline[k-1];
            dline[0] <= bus.in_data;
            idx      <= '0;
            acc      <= '0;
         end else if (state == IDLE && clr) begin
            for (int k = 0; k < TAPS; k++) dline[k] <= '0;
         end
         if (state == MAC) begin
            acc <= acc_nx_c;
            idx <= idx + IDX_W'(1);
            if (idx == IDX_LAST) bus.out_data <= res_c;
         end
      end
   end
endmodule

// File: tb/tb_bc_fir_seq.sv
// Directed bench for bc_fir_seq: impulse, backpressure/latency, clear,
// step, full-scale input and asynchronous reset mid-MAC.
module tb_bc_fir_seq;
   localparam int unsigned N = 12;

`ifdef BC_FIR_SEQ_SAT_EN
   localparam int STEP_EXP  = 4095;
   localparam int MAX1_EXP  = 4095;
   localparam int MAX_EXP   = 4095;
`else
   localparam int STEP_EXP  = 8214 % 4096;           // 22
   localparam int MAX1_EXP  = (999 * 4095) % 4096;   // 3097
   localparam int MAX_EXP   = (8214 * 4095) % 4096;  // 4074
`endif

   logic clk;
   logic rst_n;
   logic clr;
   logic busy;
   int   n_cmp;
   int   n_err;

   bc_fir_seq_if #(.N(N)) bus ();

   bc_fir_seq #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present a sample and return #1 after the accepting edge
   task automatic start(input int d);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = N'(d);
      n = 0;
      while (!bus.in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Wait for the result; lat counts edges from acceptance to the first edge seeing out_valid
   task automatic finish(output int res, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 30);
      if (lat >= 30) chk("out_valid_timeout", 0, 1);
      res = int'(bus.out_data);
      if (bus.out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic xfer(input int d, output int res, output int lat);
      start(d);
      finish(res, lat);
   endtask

   initial begin
      int r, lat;
      int imp [20];
      n_cmp = 0;
      n_err = 0;
      imp = '{999, 0, 888, 0, 777, 0, 666, 0, 555, 444,
              555, 0, 666, 0, 777, 0, 888, 0, 999, 0};
      rst_n         = 1'b0;
      clr           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  int'(bus.in_ready),  1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_busy",      int'(busy),          0);
      chk("rst_out_data",  int'(bus.out_data),  0);
      rst_n = 1'b1;

      // Impulse response
      for (int i = 0; i < 20; i++) begin
         xfer((i == 0) ? 1 : 0, r, lat);
         chk($sformatf("impulse_%0d", i), r, imp[i]);
         if (i == 0) chk("latency", lat, 7);
      end

      // Backpressure: hold the result, ignore in_valid while busy
      bus.out_ready = 1'b0;
      start(3);
      finish(r, lat);
      chk("bp_result", r, 2997);
      chk("bp_latency", lat, 7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = (i == 1);
         bus.in_data  = N'(100);
         chk($sformatf("bp_hold_data_%0d", i),  int'(bus.out_data),  2997);
         chk($sformatf("bp_hold_ready_%0d", i), int'(bus.in_ready),  0);
         chk($sformatf("bp_hold_valid_%0d", i), int'(bus.out_valid), 1);
         chk($sformatf("bp_hold_busy_%0d", i),  int'(busy),          1);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_in_ready",  int'(bus.in_ready),  1);
      chk("bp_release_out_valid", int'(bus.out_valid), 0);
      chk("bp_release_busy",      int'(busy),          0);
      xfer(0, r, lat);
      chk("bp_no_accept_a", r, 0);
      xfer(0, r, lat);
      chk("bp_no_accept_b", r, 888 * 3);

      // Clear in IDLE, then clear colliding with a handshake
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      xfer(2, r, lat);
      chk("clr_result", r, 1998);
      clr = 1'b1;
      xfer(3, r, lat);
      clr = 1'b0;
      chk("clr_hs_result", r, 2997);
      xfer(0, r, lat);
      chk("clr_hs_shifted", r, 1776);

      // Step response
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         xfer(1, r, lat);
         if (i == 1)  chk("step_1",  r, 999);
         if (i == 19) chk("step_19", r, STEP_EXP);
         if (i == 25) chk("step_25", r, STEP_EXP);
      end

      // Full-scale input
      for (int i = 1; i <= 19; i++) begin
         xfer(4095, r, lat);
         if (i == 19) chk("max_19", r, MAX_EXP);
      end
      xfer(4095, r, lat);
      chk("max_20", r, MAX_EXP);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      xfer(4095, r, lat);
      chk("max_1", r, MAX1_EXP);

      // Asynchronous reset while idx = 3
      for (int i = 0; i < 19; i++) xfer(4095, r, lat);
      start(5);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready",  int'(bus.in_ready),  1);
      chk("arst_out_valid", int'(bus.out_valid), 0);
      chk("arst_busy",      int'(busy),          0);
      chk("arst_out_data",  int'(bus.out_data),  0);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(1, r, lat);
      chk("post_rst_impulse_0", r, 999);
      xfer(0, r, lat);
      chk("post_rst_impulse_1", r, 0);
      xfer(0, r, lat);
      chk("post_rst_impulse_2", r, 888);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
